// File: rtl/cdc_handshake_tx_if.sv
// Signal bundle between the local producer, the transmit FSM and the remote 4-phase receiver.
// master is the transmitter side; slave is the producer/remote side.
interface cdc_handshake_tx_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  src_valid;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_ready;
    logic                  xfer_req;
    logic [DATA_WIDTH-1:0] xfer_data;
    logic                  xfer_ack;
    logic                  done;
    logic                  stall_err;

    modport master (
        input  src_valid, src_data, xfer_ack,
        output src_ready, xfer_req, xfer_data, done, stall_err
    );

    modport slave (
        output src_valid, src_data, xfer_ack,
        input  src_ready, xfer_req, xfer_data, done, stall_err
    );
endinterface

// File: rtl/cdc_handshake_tx.sv
// Source-side end of a 4-phase req/ack crossing: captures a word, holds it on xfer_data,
// drives xfer_req and waits on a synchronized copy of the remote xfer_ack.
module cdc_handshake_tx #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input logic                clk,
    input logic                rst_n,
    cdc_handshake_tx_if.master bus
);

    typedef enum logic [1:0] {StIdle, StReq, StAckLow} state_e;

    localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

    state_e                  state_q, state_d;
    logic                    req_q, req_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    done_q, done_d;
    logic                    stall_q, stall_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0]  ack_sync_q;
    logic [SYNC_STAGES-1:0]  init_q;
    logic                    ack_s;
    logic                    src_ready;

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    // init_q keeps src_ready low until SYNC_STAGES edges after reset release,
    // giving the ack chain time to flush a stale remote level.
    assign src_ready = (state_q == StIdle) && !ack_s && init_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync_q <= '0;
            init_q     <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.xfer_ack};
            init_q     <= {init_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.src_valid && src_ready) begin
                    data_d  = bus.src_data;
                    req_d   = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = StAckLow;
                end
            end
            StAckLow: begin
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = StIdle;
            end
        endcase

        // Phase timer: restarts on every transition, saturates, never aborts the handshake.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != StIdle && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
        stall_d = stall_q || (cnt_d >= TimeoutCnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            stall_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
            stall_q <= stall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.src_ready = src_ready;
    assign bus.xfer_req  = req_q;
    assign bus.xfer_data = data_q;
    assign bus.done      = done_q;
    assign bus.stall_err = stall_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Scoreboard bench for cdc_handshake_tx: driver pushes accepted words, a monitor pops them
// on done pulses; a remote-receiver model answers req with configurable delays.
module tb_cdc_handshake_tx;

    localparam int DW   = 8;
    localparam int SYNC = 2;
    localparam int TO   = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] exp_q[$];
    int accepts  = 0;
    int done_cnt = 0;

    int   rise_dly = 2;
    int   drop_dly = 2;
    bit   ack_force = 1'b1;
    logic ack_force_val = 1'b1;
    int   ack_rise_cyc = 0;
    int   ack_fall_cyc = 0;

    cdc_handshake_tx_if #(.DATA_WIDTH(DW)) intf ();

    cdc_handshake_tx #(
        .DATA_WIDTH (DW),
        .SYNC_STAGES(SYNC),
        .TIMEOUT    (TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (intf)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Remote receiver: raises ack rise_dly cycles after seeing req, drops it drop_dly
    // cycles after req falls.
    initial begin
        int rcnt;
        rcnt = 0;
        intf.xfer_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_force) begin
                intf.xfer_ack = ack_force_val;
                rcnt = 0;
            end else if (!rst_n) begin
                intf.xfer_ack = 1'b0;
                rcnt = 0;
            end else if (intf.xfer_req && !intf.xfer_ack) begin
                if (rcnt >= rise_dly) begin
                    intf.xfer_ack = 1'b1;
                    ack_rise_cyc = cyc;
                    rcnt = 0;
                end else rcnt++;
            end else if (!intf.xfer_req && intf.xfer_ack) begin
                if (rcnt >= drop_dly) begin
                    intf.xfer_ack = 1'b0;
                    ack_fall_cyc = cyc;
                    rcnt = 0;
                end else rcnt++;
            end else begin
                rcnt = 0;
            end
        end
    end

    // Monitor: pops expected words on done, checks hold stability and phase latencies.
    initial begin
        logic prev_req;
        logic prev_done;
        logic [DW-1:0] e;
        prev_req  = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req  = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (intf.done) begin
                    done_cnt++;
                    chk("done_latency", cyc - ack_fall_cyc, SYNC + 1);
                    chk("done_single", int'(prev_done), 0);
                    chk("done_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("done_data", int'(intf.xfer_data), int'(e));
                    end
                end
                if (intf.xfer_req && exp_q.size() > 0)
                    chk("hold_data", int'(intf.xfer_data), int'(exp_q[0]));
                if (prev_req && !intf.xfer_req)
                    chk("req_fall_latency", cyc - ack_rise_cyc, SYNC + 1);
                prev_req  = intf.xfer_req;
                prev_done = intf.done;
            end
        end
    end

    // Called at a negedge; returns at the negedge one cycle after the accepting edge.
    task automatic send(input logic [DW-1:0] w, input bit keep);
        int n;
        n = 0;
        intf.src_valid = 1'b1;
        intf.src_data  = w;
        while (!intf.src_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", int'(n < 300), 1);
        if (n >= 300) begin
            intf.src_valid = 1'b0;
            return;
        end
        chk("in_order", int'((done_cnt + int'(intf.done)) >= accepts), 1);
        exp_q.push_back(w);
        accepts++;
        @(negedge clk);
        chk("req_rise", int'(intf.xfer_req), 1);
        chk("ready_busy", int'(intf.src_ready), 0);
        chk("capture_data", int'(intf.xfer_data), int'(w));
        if (!keep) intf.src_valid = 1'b0;
        intf.src_data = DW'($urandom);
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("done_wait", int'(done_cnt >= target), 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int n;
        rst_n          = 1'b0;
        intf.src_valid = 1'b0;
        intf.src_data  = '0;

        // Reset with remote ack held high.
        idle(3);
        chk("rst_req", int'(intf.xfer_req), 0);
        chk("rst_data", int'(intf.xfer_data), 0);
        chk("rst_done", int'(intf.done), 0);
        chk("rst_stall", int'(intf.stall_err), 0);
        chk("rst_ready", int'(intf.src_ready), 0);
        ack_force_val = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        chk("ready_early", int'(intf.src_ready), 0);
        idle(1);
        chk("ready_after_sync", int'(intf.src_ready), 1);
        ack_force = 1'b0;

        // Single transfer.
        rise_dly = 2;
        drop_dly = 2;
        send(8'hA5, 1'b0);
        wait_done(accepts);
        idle(1);
        chk("data_held_after_done", int'(intf.xfer_data), 'hA5);
        chk("done_one_pulse", done_cnt, 1);

        // Back-to-back with src_valid held high.
        for (int i = 1; i <= 4; i++) send(DW'(i), 1'b1);
        intf.src_valid = 1'b0;
        wait_done(accepts);

        // Word offered while busy must wait for the previous done.
        send(8'h5A, 1'b0);
        intf.src_valid = 1'b1;
        intf.src_data  = 8'hFF;
        send(8'hFF, 1'b0);
        wait_done(accepts);

        // Spurious ack in IDLE blocks src_ready without starting anything.
        idle(2);
        ack_force_val = 1'b1;
        ack_force     = 1'b1;
        idle(3);
        chk("spurious_ack_ready", int'(intf.src_ready), 0);
        chk("spurious_ack_req", int'(intf.xfer_req), 0);
        ack_force_val = 1'b0;
        idle(3);
        chk("spurious_ack_clear", int'(intf.src_ready), 1);
        ack_force = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 16; i++) begin
            rise_dly = $urandom_range(0, 3);
            drop_dly = $urandom_range(0, 3);
            idle($urandom_range(0, 3));
            send(DW'($urandom), 1'($urandom_range(0, 1)));
        end
        intf.src_valid = 1'b0;
        wait_done(accepts);
        chk("no_stall_yet", int'(intf.stall_err), 0);

        // Timeout: ack withheld well past TIMEOUT, then arrives late.
        rise_dly = 20;
        send(8'hC3, 1'b0);
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk);
            chk("stall_timing", int'(intf.stall_err), (k == 9) ? 1 : 0);
            chk("stall_req_held", int'(intf.xfer_req), 1);
        end
        wait_done(accepts);
        idle(2);
        chk("stall_sticky", int'(intf.stall_err), 1);
        rise_dly = 1;

        // Reset asserted while in ACK_LOW.
        drop_dly = 6;
        send(8'h77, 1'b0);
        n = 0;
        while (intf.xfer_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_ack_low", int'(n < 100), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_req", int'(intf.xfer_req), 0);
        chk("midrst_data", int'(intf.xfer_data), 0);
        chk("midrst_done", int'(intf.done), 0);
        chk("midrst_stall", int'(intf.stall_err), 0);
        chk("midrst_ready", int'(intf.src_ready), 0);
        exp_q.delete();
        accepts  = 0;
        done_cnt = 0;
        drop_dly = 2;
        idle(3);
        rst_n = 1'b1;
        send(8'h3C, 1'b0);
        wait_done(1);
        idle(4);
        chk("post_reset_done", done_cnt, 1);

        chk("done_total", done_cnt, accepts);
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
